// File: rtl/wb_regfile_if.sv
// WriteBack-stage bundle: MEM/WB pipeline fields in, Decode read ports and
// writeback status out. The master drives the pipeline side; the slave is the stage.
interface wb_regfile_if #(
  parameter int CNT_WIDTH = 64
);
  logic                 ValidW;
  logic                 RegWriteW;
  logic [1:0]           ResultSrcW;
  logic [31:0]          InstrW;
  logic [31:0]          ALUResultW;
  logic [31:0]          ReadDataW;
  logic [31:0]          PCPlus4W;
  logic [31:0]          ImmExtW;
  logic [4:0]           RdW;
  logic [4:0]           Rs1D;
  logic [4:0]           Rs2D;
  logic [31:0]          RD1D;
  logic [31:0]          RD2D;
  logic [31:0]          ResultW;
  logic                 RegWrEnW;
  logic                 MisalignW;
  logic [CNT_WIDTH-1:0] InstretCnt;

  modport master (
    output ValidW, RegWriteW, ResultSrcW, InstrW, ALUResultW, ReadDataW,
           PCPlus4W, ImmExtW, RdW, Rs1D, Rs2D,
    input  RD1D, RD2D, ResultW, RegWrEnW, MisalignW, InstretCnt
  );

  modport slave (
    input  ValidW, RegWriteW, ResultSrcW, InstrW, ALUResultW, ReadDataW,
           PCPlus4W, ImmExtW, RdW, Rs1D, Rs2D,
    output RD1D, RD2D, ResultW, RegWrEnW, MisalignW, InstretCnt
  );
endinterface

// File: rtl/wb_regfile_stage.sv
// WriteBack stage plus architectural register file: result select, sub-word
// load extension, x1..x31 storage with write->read bypass, retired-instruction counter.
module wb_regfile_stage #(
  parameter int CNT_WIDTH = 64,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave wb
);
  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  logic [31:0]          regs_reg [32];
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 misalign_reg;

  logic [1:0]  offset;
  logic [2:0]  funct3;
  logic        is_load;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] result;
  logic        misaligned;
  logic        illegal;
  logic        bad;
  logic        wr_en;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^{wb.InstrW[31:15], wb.InstrW[11:7]};

  assign offset  = wb.ALUResultW[1:0];
  assign funct3  = wb.InstrW[14:12];
  assign is_load = (wb.InstrW[6:0] == OPC_LOAD) && (wb.ResultSrcW == 2'b01);
  assign shifted = wb.ReadDataW >> {offset, 3'b000};

  // ResultSrcW==01 without a load opcode falls through as raw word data
  always_comb begin
    load_data  = wb.ReadDataW;
    misaligned = 1'b0;
    illegal    = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
        3'b100:  load_data = {24'h0, shifted[7:0]};
        3'b001: begin
          load_data  = {{16{shifted[15]}}, shifted[15:0]};
          misaligned = offset[0];
        end
        3'b101: begin
          load_data  = {16'h0, shifted[15:0]};
          misaligned = offset[0];
        end
        3'b010:  misaligned = (offset != 2'b00);
        default: illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    result = wb.ALUResultW;
    case (wb.ResultSrcW)
      2'b01:   result = load_data;
      2'b10:   result = wb.PCPlus4W;
      2'b11:   result = wb.ImmExtW;
      default: result = wb.ALUResultW;
    endcase
  end

  assign bad   = wb.ValidW && is_load && (misaligned || illegal);
  assign wr_en = wb.ValidW && wb.RegWriteW && (wb.RdW != 5'd0) && !bad;

  // Both Decode read ports share identical bypass/x0 logic
  logic [4:0]  rs_addr [2];
  logic [31:0] rs_data [2];
  assign rs_addr[0] = wb.Rs1D;
  assign rs_addr[1] = wb.Rs2D;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        if (rs_addr[gi] == 5'd0)
          rs_data[gi] = 32'h0;
        else if (BYPASS_EN && wr_en && (wb.RdW == rs_addr[gi]))
          rs_data[gi] = result;
        else
          rs_data[gi] = regs_reg[rs_addr[gi]];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_reg[i] <= 32'h0;
      cnt_reg      <= '0;
      misalign_reg <= 1'b0;
    end else begin
      if (wr_en) regs_reg[wb.RdW] <= result;
      if (wb.ValidW && !bad) cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      misalign_reg <= bad;
    end
  end

  assign wb.RD1D       = rs_data[0];
  assign wb.RD2D       = rs_data[1];
  assign wb.ResultW    = result;
  assign wb.RegWrEnW   = wr_en;
  assign wb.MisalignW  = misalign_reg;
  assign wb.InstretCnt = cnt_reg;
endmodule
